// File: rtl/window_scan_sequencer.sv
// Column sequencer for a 3x3 sliding-window scan over a COLS x ROWS frame.
// Tracks the accepted column position and flags when the window is complete.
module window_scan_sequencer #(
  parameter int COLS = 5,
  parameter int ROWS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    done_i,
  input  logic                    clear_i,
  output logic                    shift_en_o,
  output logic                    win_valid_o,
  output logic [$clog2(COLS)-1:0] col_o,
  output logic [$clog2(ROWS)-1:0] row_o,
  output logic                    busy_o,
  output logic                    progress_done_o
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 3);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx;
  logic [RW-1:0] row, row_nx;
  logic          win_nx;
  logic          accept;
  logic          col_last;
  logic          row_last;

  assign accept   = done_i & ~clear_i & (state != DONE);
  assign col_last = (col == COL_MAX);
  assign row_last = (row == ROW_MAX);

  always_comb begin
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    win_nx   = accept & (col >= CW'(2));
    if (clear_i) begin
      state_nx = IDLE;
      col_nx   = '0;
      row_nx   = '0;
      win_nx   = 1'b0;
    end else begin
      if (accept) begin
        col_nx = col_last ? '0 : col + CW'(1);
        if (col_last)
          row_nx = row_last ? '0 : row + RW'(1);
      end
      unique case (state)
        IDLE: if (accept) state_nx = FILL;
        FILL: if (accept && col == CW'(1)) state_nx = RUN;
        RUN: begin
          if (accept && col_last)
            state_nx = row_last ? DONE : FILL;
        end
        DONE: state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      win_valid_o <= 1'b0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row         <= row_nx;
      win_valid_o <= win_nx;
    end
  end

  // Position of the last accepted column; col == 0 means it closed a row.
  always_comb begin
    col_o = (col == '0) ? COL_MAX : col - CW'(1);
    row_o = row;
    if (col == '0)
      row_o = (row == '0) ? ROW_MAX : row - RW'(1);
  end

  assign shift_en_o      = accept & rst;
  assign busy_o          = (state == FILL) || (state == RUN);
  assign progress_done_o = (state == DONE);

endmodule

// File: tb/tb_window_scan_sequencer.sv
// Directed bench for window_scan_sequencer (COLS=5, ROWS=5).
// Expected post-edge outputs are queued per step and popped after the edge.
module tb_window_scan_sequencer;

  localparam int COLS = 5;
  localparam int ROWS = 5;
  localparam int FRAME = COLS * (ROWS - 2);

  logic       clk = 1'b0;
  logic       rst;
  logic       done_i;
  logic       clear_i;
  logic       shift_en_o;
  logic       win_valid_o;
  logic [2:0] col_o;
  logic [2:0] row_o;
  logic       busy_o;
  logic       progress_done_o;

  window_scan_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk),
    .rst(rst),
    .done_i(done_i),
    .clear_i(clear_i),
    .shift_en_o(shift_en_o),
    .win_valid_o(win_valid_o),
    .col_o(col_o),
    .row_o(row_o),
    .busy_o(busy_o),
    .progress_done_o(progress_done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       win;
    logic       busy;
    logic       prog;
    logic       pos;
    logic [2:0] col;
    logic [2:0] row;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   m_k = 0;
  bit   m_done = 0;
  int   win_cnt = 0;
  int   prog_cnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step(input logic d, input logic c);
    exp_t e;
    int   cc;
    int   rr;
    @(negedge clk);
    done_i  = d;
    clear_i = c;
    #1;
    chk("shift_en", {7'd0, shift_en_o}, {7'd0, d && !c && !m_done});
    e = '{win: 0, busy: 0, prog: 0, pos: 0, col: 0, row: 0};
    if (c) begin
      m_k    = 0;
      m_done = 0;
    end else if (m_done) begin
      m_k    = 0;
      m_done = 0;
    end else if (d) begin
      m_k++;
      cc    = (m_k - 1) % COLS;
      rr    = (m_k - 1) / COLS;
      e.win = (cc >= 2);
      e.pos = 1;
      e.col = 3'(cc);
      e.row = 3'(rr);
      if (m_k == FRAME) begin
        m_done = 1;
        e.prog = 1;
      end else begin
        e.busy = 1;
      end
    end else if (m_k > 0) begin
      e.busy = 1;
      e.pos  = 1;
      e.col  = 3'((m_k - 1) % COLS);
      e.row  = 3'((m_k - 1) / COLS);
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("win_valid", {7'd0, win_valid_o}, {7'd0, e.win});
    chk("busy", {7'd0, busy_o}, {7'd0, e.busy});
    chk("progress_done", {7'd0, progress_done_o}, {7'd0, e.prog});
    if (e.pos) begin
      chk("col_o", {5'd0, col_o}, {5'd0, e.col});
      chk("row_o", {5'd0, row_o}, {5'd0, e.row});
    end
    if (win_valid_o) win_cnt++;
    if (progress_done_o) prog_cnt++;
  endtask

  task automatic full_frame();
    win_cnt  = 0;
    prog_cnt = 0;
    repeat (FRAME) step(1, 0);
    step(0, 0);
    step(0, 0);
    chk("frame_windows", 8'(win_cnt), 8'd9);
    chk("frame_done_pulses", 8'(prog_cnt), 8'd1);
  endtask

  initial begin
    rst     = 1'b0;
    done_i  = 1'b0;
    clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    done_i = 1'b1;
    #1;
    chk("rst_shift_en", {7'd0, shift_en_o}, 8'd0);
    chk("rst_win_valid", {7'd0, win_valid_o}, 8'd0);
    chk("rst_busy", {7'd0, busy_o}, 8'd0);
    chk("rst_progress", {7'd0, progress_done_o}, 8'd0);
    done_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Continuous stream: three bursts of windows, one done pulse.
    full_frame();

    // Alternating accepts over one row.
    win_cnt = 0;
    repeat (COLS) begin
      step(1, 0);
      step(0, 0);
    end
    chk("alt_windows", 8'(win_cnt), 8'd3);
    step(0, 1);

    // done_i held through DONE and into the next frame.
    repeat (FRAME + 2) step(1, 0);
    step(0, 1);

    // Abort at row 1, column 3.
    repeat (COLS + 3) step(1, 0);
    prog_cnt = 0;
    step(1, 1);
    repeat (3) step(0, 0);
    chk("abort_no_done", 8'(prog_cnt), 8'd0);

    // Asynchronous reset at row 2, column 4.
    repeat (2 * COLS + 4) step(1, 0);
    #1;
    rst    = 1'b0;
    done_i = 1'b1;
    #1;
    chk("arst_shift_en", {7'd0, shift_en_o}, 8'd0);
    chk("arst_win_valid", {7'd0, win_valid_o}, 8'd0);
    chk("arst_busy", {7'd0, busy_o}, 8'd0);
    chk("arst_progress", {7'd0, progress_done_o}, 8'd0);
    done_i = 1'b0;
    #3;
    rst    = 1'b1;
    m_k    = 0;
    m_done = 0;
    full_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
